// File: rtl/key_repeat_filter_if.sv
// Keycode-in / command-out bundle between the keyboard register, the repeat filter and the motion block.
interface key_repeat_filter_if;
    logic [7:0] keycode_in;
    logic [7:0] key_out;
    logic       key_pulse;
    logic       key_held;
    logic [9:0] held_frames;

    modport master (
        output keycode_in,
        input  key_out,
        input  key_pulse,
        input  key_held,
        input  held_frames
    );

    modport slave (
        input  keycode_in,
        output key_out,
        output key_pulse,
        output key_held,
        output held_frames
    );
endinterface

// File: rtl/key_repeat_filter.sv
// W/A/S/D whitelist and frame-aligned auto-repeat for the raw keycode register.
// One pulse per press edge, then a repeat after REPEAT_DELAY frames and every REPEAT_PERIOD frames.
module key_repeat_filter #(
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 15,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input logic                frame_clk,
    input logic                Reset,
    key_repeat_filter_if.slave bus
);

    localparam logic [9:0] DELAY_LAST  = 10'(REPEAT_DELAY - 1);
    localparam logic [9:0] PERIOD_LAST = 10'(REPEAT_PERIOD - 1);
    localparam logic [9:0] HELD_MAX    = 10'd1023;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t     state;
    logic [7:0] latched;
    logic [9:0] cnt;
    logic [7:0] filtered;

    // NOTE: always_comb assigns filtered on every path (default arm), so no latch is inferred.
    always_comb begin
        filtered = 8'h00;
        case (bus.keycode_in)
            KEY_W, KEY_A, KEY_S, KEY_D: filtered = bus.keycode_in;
            default:                    filtered = 8'h00;
        endcase
    end

    // NOTE: all state and outputs update with <= so every read in this block sees pre-edge values.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state           <= IDLE;
            latched         <= 8'h00;
            cnt             <= 10'd0;
            bus.key_out     <= 8'h00;
            bus.key_pulse   <= 1'b0;
            bus.key_held    <= 1'b0;
            bus.held_frames <= 10'd0;
        end else begin
            // Pulse is one frame wide unless a branch below re-asserts it.
            bus.key_out   <= 8'h00;
            bus.key_pulse <= 1'b0;

            if (filtered != 8'h00 && filtered != latched) begin
                // New press, including a direct switch between movement keys.
                bus.key_out     <= filtered;
                bus.key_pulse   <= 1'b1;
                bus.key_held    <= 1'b1;
                bus.held_frames <= 10'd0;
                latched         <= filtered;
                cnt             <= 10'd0;
                state           <= REPEAT_EN ? DELAY : REPEAT;
            end else if (filtered == 8'h00) begin
                state           <= IDLE;
                latched         <= 8'h00;
                cnt             <= 10'd0;
                bus.key_held    <= 1'b0;
                bus.held_frames <= 10'd0;
            end else begin
                if (bus.held_frames != HELD_MAX) begin
                    bus.held_frames <= bus.held_frames + 10'd1;
                end

                case (state)
                    DELAY: begin
                        if (cnt == DELAY_LAST) begin
                            bus.key_out   <= latched;
                            bus.key_pulse <= 1'b1;
                            cnt           <= 10'd0;
                            state         <= REPEAT;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    REPEAT: begin
                        // With repeat disabled the press pulse is the only one; cnt stays put.
                        if (REPEAT_EN) begin
                            if (cnt == PERIOD_LAST) begin
                                bus.key_out   <= latched;
                                bus.key_pulse <= 1'b1;
                                cnt           <= 10'd0;
                            end else begin
                                cnt <= cnt + 10'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_filter.sv
// Directed-vector bench for key_repeat_filter: one instance with auto-repeat, one with it disabled.
module tb_key_repeat_filter;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_checks  = 0;
    int   n_errors  = 0;

    key_repeat_filter_if bus0 ();
    key_repeat_filter_if bus1 ();

    always #5 frame_clk = ~frame_clk;

    key_repeat_filter #(
        .REPEAT_EN    (1'b1),
        .REPEAT_DELAY (15),
        .REPEAT_PERIOD(4)
    ) dut_rep (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus0)
    );

    key_repeat_filter #(
        .REPEAT_EN    (1'b0),
        .REPEAT_DELAY (15),
        .REPEAT_PERIOD(4)
    ) dut_norep (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .bus      (bus1)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one input frame away from the edge, then settle just after the sampling edge.
    task automatic frame(input logic [7:0] k0, input logic [7:0] k1, input logic rst);
        @(negedge frame_clk);
        bus0.keycode_in = k0;
        bus1.keycode_in = k1;
        Reset           = rst;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic expect_rep(input string tag, input logic [7:0] ko, input logic p,
                              input logic h, input int hf);
        check({tag, "_key_out"}, 32'(bus0.key_out), 32'(ko));
        check({tag, "_pulse"}, 32'(bus0.key_pulse), 32'(p));
        check({tag, "_held"}, 32'(bus0.key_held), 32'(h));
        check({tag, "_held_frames"}, 32'(bus0.held_frames), 32'(hf));
    endtask

    task automatic expect_norep(input string tag, input logic [7:0] ko, input logic p,
                                input logic h, input int hf);
        check({tag, "_key_out"}, 32'(bus1.key_out), 32'(ko));
        check({tag, "_pulse"}, 32'(bus1.key_pulse), 32'(p));
        check({tag, "_held"}, 32'(bus1.key_held), 32'(h));
        check({tag, "_held_frames"}, 32'(bus1.held_frames), 32'(hf));
    endtask

    initial begin
        logic p;
        int   pulses;
        bus0.keycode_in = 8'h00;
        bus1.keycode_in = 8'h00;

        // Reset for two frames.
        repeat (2) frame(8'h00, 8'h00, 1'b1);
        expect_rep("reset", 8'h00, 1'b0, 1'b0, 0);
        expect_norep("reset_norep", 8'h00, 1'b0, 1'b0, 0);

        // W held 30 frames: pulses at 0, 15, 19, 23, 27.
        for (int i = 0; i < 30; i++) begin
            frame(KEY_W, 8'h00, 1'b0);
            p = (i == 0) || (i == 15) || (i == 19) || (i == 23) || (i == 27);
            expect_rep("w_hold", p ? KEY_W : 8'h00, p, 1'b1, i);
        end
        frame(8'h00, 8'h00, 1'b0);
        expect_rep("w_release", 8'h00, 1'b0, 1'b0, 0);

        // A for 3 frames, release, A again is a fresh press.
        for (int i = 0; i < 3; i++) begin
            frame(KEY_A, 8'h00, 1'b0);
            expect_rep("a_short", (i == 0) ? KEY_A : 8'h00, i == 0, 1'b1, i);
        end
        frame(8'h00, 8'h00, 1'b0);
        expect_rep("a_release", 8'h00, 1'b0, 1'b0, 0);
        frame(KEY_A, 8'h00, 1'b0);
        expect_rep("a_repress", KEY_A, 1'b1, 1'b1, 0);
        frame(8'h00, 8'h00, 1'b0);
        expect_rep("a_release2", 8'h00, 1'b0, 1'b0, 0);

        // A for 10 frames, then straight to D: D pulses at once and again 15 frames later.
        for (int i = 0; i < 10; i++) begin
            frame(KEY_A, 8'h00, 1'b0);
            expect_rep("a_long", (i == 0) ? KEY_A : 8'h00, i == 0, 1'b1, i);
        end
        for (int j = 0; j < 17; j++) begin
            frame(KEY_D, 8'h00, 1'b0);
            p = (j == 0) || (j == 15);
            expect_rep("a_to_d", p ? KEY_D : 8'h00, p, 1'b1, j);
        end
        frame(8'h00, 8'h00, 1'b0);
        expect_rep("d_release", 8'h00, 1'b0, 1'b0, 0);

        // Space bar is filtered out entirely; a later W still works.
        for (int i = 0; i < 20; i++) begin
            frame(KEY_SPACE, 8'h00, 1'b0);
            expect_rep("space", 8'h00, 1'b0, 1'b0, 0);
        end
        frame(KEY_W, 8'h00, 1'b0);
        expect_rep("w_after_space", KEY_W, 1'b1, 1'b1, 0);
        frame(KEY_W, 8'h00, 1'b0);
        expect_rep("w_after_space_hold", 8'h00, 1'b0, 1'b1, 1);
        frame(8'h00, 8'h00, 1'b0);

        // Reset while W is held, then release reset with W still down.
        for (int i = 0; i < 17; i++) begin
            frame(KEY_W, 8'h00, 1'b0);
            p = (i == 0) || (i == 15);
            expect_rep("w_pre_reset", p ? KEY_W : 8'h00, p, 1'b1, i);
        end
        repeat (2) begin
            frame(KEY_W, 8'h00, 1'b1);
            expect_rep("w_in_reset", 8'h00, 1'b0, 1'b0, 0);
        end
        for (int j = 0; j < 17; j++) begin
            frame(KEY_W, 8'h00, 1'b0);
            p = (j == 0) || (j == 15);
            expect_rep("w_post_reset", p ? KEY_W : 8'h00, p, 1'b1, j);
        end
        frame(8'h00, 8'h00, 1'b0);
        expect_rep("w_post_reset_release", 8'h00, 1'b0, 1'b0, 0);

        // Repeat disabled: S held 1100 frames gives one pulse, held_frames saturates at 1023.
        pulses = 0;
        for (int j = 0; j < 1100; j++) begin
            frame(8'h00, KEY_S, 1'b0);
            if (bus1.key_pulse === 1'b1) pulses++;
            expect_norep("s_norep", (j == 0) ? KEY_S : 8'h00, j == 0, 1'b1, (j > 1023) ? 1023 : j);
        end
        check("s_norep_pulse_count", 32'(pulses), 32'd1);
        frame(8'h00, 8'h00, 1'b0);
        expect_norep("s_norep_release", 8'h00, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
